// File: rtl/serial_add_ctrl_pkg.sv
// adder_pkg: constants and types shared by the nibble-serial adder
// controller, its bus interface and the testbench.
//   NIBBLE_W : width of one adder slice (4 bits)
//   state_t  : controller FSM state (IDLE, RUN)
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/result bus between a requesting datapath
// (master) and the nibble-serial adder controller (slave).
//   start       : request, sampled only while the controller is idle
//   A, B, cin   : operands and carry-in, sampled on the accepting edge
//   sub         : subtract request (only when ADD_SUB_EN is defined)
//   busy        : high from the accepting edge until the result edge
//   done        : one-cycle pulse after the result edge
//   sum, co     : result and carry-out, held until the next accepted start
// Optional feature macro: ADD_SUB_EN (adds the sub signal).
interface serial_add_ctrl_if #(
  parameter int NIBBLES = 4
) ();
  import adder_pkg::*;

  localparam int W = NIBBLE_W * NIBBLES;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         cin;
`ifdef ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         co;

`ifdef ADD_SUB_EN
  modport master (output start, A, B, cin, sub, input busy, done, sum, co);
  modport slave  (input start, A, B, cin, sub, output busy, done, sum, co);
`else
  modport master (output start, A, B, cin, input busy, done, sum, co);
  modport slave  (input start, A, B, cin, output busy, done, sum, co);
`endif

endinterface

// File: rtl/serial_add_ctrl_nibble_adder.sv
// nibble_adder: combinational 4-bit adder slice with carry in/out.
//   a, b : 4-bit operands
//   cin  : carry-in
//   sum  : 4-bit sum
//   co   : carry-out
module nibble_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       co
);

  assign {co, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: nibble-serial multi-word adder controller. Reuses one
// 4-bit adder for NIBBLES cycles, least-significant nibble first, with the
// carry rippled through a register, so {co,sum} = A + B + cin.
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : serial_add_ctrl_if slave (start/A/B/cin[/sub] in,
//               busy/done/sum/co out)
//   dbg_state : current FSM state, for observation only
// Optional feature macro: ADD_SUB_EN -- sub=1 at accept loads ~B and
// forces carry-in to 1, giving A - B (co=1 means no borrow).
//
// Handshake: start is sampled only in IDLE; the edge on which it is seen
// is the accepting edge. busy is high from that edge to the result edge;
// done pulses for exactly one cycle after the result edge, together with
// the new sum/co. start during RUN is dropped, not queued.
module serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_add_ctrl_if.slave     bus,
  output state_t               dbg_state
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  res_q, res_d;
  logic          carry_q, carry_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          co_q, co_d;

  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_co;
  logic [W-1:0]        res_next;

  nibble_adder u_nibble_adder (
    .a   (a_sh_q[NIBBLE_W-1:0]),
    .b   (b_sh_q[NIBBLE_W-1:0]),
    .cin (carry_q),
    .sum (nib_sum),
    .co  (nib_co)
  );

  // New nibble enters at the top so after NIBBLES shifts the first
  // (least significant) nibble has reached bit 0.
  assign res_next = {nib_sum, res_q[W-1:NIBBLE_W]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = done_q;
    sum_d   = sum_q;
    co_d    = co_q;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (bus.start) begin
          a_sh_d  = bus.A;
          b_sh_d  = bus.B;
          carry_d = bus.cin;
`ifdef ADD_SUB_EN
          if (bus.sub) begin
            b_sh_d  = ~bus.B;
            carry_d = 1'b1;
          end
`endif
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_next;
        carry_d = nib_co;
        a_sh_d  = a_sh_q >> NIBBLE_W;
        b_sh_d  = b_sh_q >> NIBBLE_W;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = res_next;
          co_d    = nib_co;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.co    = co_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: self-checking bench for serial_add_ctrl (NIBBLES=4).
// Table-driven operations issued back to back, plus hand-written sequences
// for a stray start during RUN, reset mid-operation and idle gaps.
// Honors ADD_SUB_EN for the subtract vectors.
module tb_serial_add_ctrl;
  import adder_pkg::*;

  localparam int NIBBLES = 4;
  localparam int W       = NIBBLE_W * NIBBLES;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_co;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst_n;
  state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [W:0] exp_q[$];
  logic [W:0] prev_res;
  logic [W:0] mon_exp;
  vec_t       vec_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
`ifdef ADD_SUB_EN
    if (s) r = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
`else
    if (s) r = 'x;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {bus.co, bus.sum}, mon_exp);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge of the done cycle, so a
  // following call issues its start in the same cycle as done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s,
                       input logic [W:0] exp_res, input int stray_at);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.cin   = c;
`ifdef ADD_SUB_EN
    bus.sub   = s;
`endif
    exp_q.push_back(exp_res);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    bus.cin   = 1'($urandom);
    for (int i = 1; i <= NIBBLES; i++) begin
      check("busy_high", {16'h0, bus.busy}, 17'h1);
      check("done_low", {16'h0, bus.done}, 17'h0);
      check("sum_hold", {bus.co, bus.sum}, prev_res);
      if (i == stray_at) begin
        bus.start = 1'b1;
        bus.A     = 16'h1111;
        bus.B     = 16'h1111;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("done_pulse", {16'h0, bus.done}, 17'h1);
    check("busy_low", {16'h0, bus.busy}, 17'h0);
    prev_res = exp_res;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t v;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.cin   = 1'b0;
`ifdef ADD_SUB_EN
    bus.sub   = 1'b0;
`endif
    prev_res  = '0;

    // Vector table
    vec_q.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
    vec_q.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    vec_q.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
    vec_q.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0});
    vec_q.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
    vec_q.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0});
`ifdef ADD_SUB_EN
    vec_q.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
    vec_q.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
    vec_q.push_back('{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1});
`endif
    for (int i = 0; i < 6; i++) begin
      v.a   = W'($urandom_range(0, 16'hFFFF));
      v.b   = W'($urandom_range(0, 16'hFFFF));
      v.cin = 1'($urandom_range(0, 1));
      v.sub = 1'b0;
`ifdef ADD_SUB_EN
      v.sub = 1'($urandom_range(0, 1));
`endif
      {v.exp_co, v.exp_sum} = model(v.a, v.b, v.cin, v.sub);
      vec_q.push_back(v);
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {16'h0, bus.busy}, 17'h0);
    check("rst_done", {16'h0, bus.done}, 17'h0);
    check("rst_result", {bus.co, bus.sum}, 17'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_state", {16'h0, dbg_state}, {16'h0, IDLE});
    check("idle_busy", {16'h0, bus.busy}, 17'h0);

    // Table applied back to back (each start coincides with previous done)
    foreach (vec_q[i])
      do_op(vec_q[i].a, vec_q[i].b, vec_q[i].cin, vec_q[i].sub,
            {vec_q[i].exp_co, vec_q[i].exp_sum}, 0);

    // Idle with start=0: done drops, result holds
    @(negedge clk);
    check("done_cleared", {16'h0, bus.done}, 17'h0);
    check("idle_hold", {bus.co, bus.sum}, prev_res);

    // Stray start during RUN is ignored and not queued
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, 2);
    repeat (NIBBLES + 2) begin
      @(negedge clk);
      check("no_second_done", {16'h0, bus.done}, 17'h0);
      check("stray_busy", {16'h0, bus.busy}, 17'h0);
    end
    check("stray_hold", {bus.co, bus.sum}, 17'h05555);

    // Reset mid-RUN aborts with no done
    bus.start = 1'b1;
    bus.A     = 16'h1234;
    bus.B     = 16'h4321;
    bus.cin   = 1'b0;
`ifdef ADD_SUB_EN
    bus.sub   = 1'b0;
`endif
    @(negedge clk);
    bus.start = 1'b0;
    check("abort_busy_pre", {16'h0, bus.busy}, 17'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {16'h0, bus.busy}, 17'h0);
    check("abort_done", {16'h0, bus.done}, 17'h0);
    check("abort_result", {bus.co, bus.sum}, 17'h0);
    check("abort_state", {16'h0, dbg_state}, {16'h0, IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    prev_res = '0;
    repeat (NIBBLES + 2) begin
      @(negedge clk);
      check("abort_no_done", {16'h0, bus.done}, 17'h0);
    end

    // Fresh operation after reset release
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 0);
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, 0);
    @(negedge clk);
    check("final_done_low", {16'h0, bus.done}, 17'h0);
    check("scoreboard_empty", 17'(exp_q.size()), 17'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Nibble-serial multi-word adder controller. Sequences one combinational 4-bit adder over NIBBLES cycles to add two 4·NIBBLES-bit operands, least-significant nibble first, rippling the carry through a register between cycles. Sits between a requesting datapath (start/done handshake) and the shared 4-bit adder. The result is identical to the full-width sum A+B+cin.

## Interface
- NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4·NIBBLES; legal range 2..16.
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- A  in  W  operand A; sampled on the accepting edge.
- B  in  W  operand B; sampled on the accepting edge.
- cin  in  1  carry-in; sampled on the accepting edge.
- sub  in  1  subtract request; present only with ADD_SUB_EN, sampled on the accepting edge.
- busy  out  1  high from the accepting edge until the result edge.
- done  out  1  one-cycle pulse after the result edge.
- sum  out  W  result; holds its value until the next accepted start.
- co  out  1  final carry-out; holds its value with sum.

## Operation
- States: IDLE, RUN. Reset forces IDLE.
- Reset values: busy=0, done=0, sum=0, co=0, nibble counter=0, carry register=0.
- IDLE with start=1:
  - Load the A and B shift registers.
  - Carry register ← cin.
  - Counter ← 0.
  - Transition to RUN.
- IDLE with start=0: no state change; done cleared to 0.
- RUN, each cycle:
  - Adder inputs: A[3:0], B[3:0] and the carry register.
  - The nibble sum shifts into the top of the result shift register.
  - Carry register ← adder carry-out.
  - A and B shift right by 4; counter increments.
- RUN, when counter == NIBBLES-1 (the final nibble is computed on this edge):
  - sum ← full result.
  - co ← final carry.
  - done ← 1.
  - Transition to IDLE.
- sum/co change only on the result edge. Intermediate nibbles are kept in an internal shift register and never appear on sum.
- start in RUN is ignored. It is not queued.
- start=1 on the cycle done=1: accepted (FSM is in IDLE). done drops the next cycle.
- Arithmetic: {co,sum} = A + B + cin, modulo 2^(W+1). No overflow flag.
- Counter width: ceil(log2(NIBBLES)). Wrap-around of the counter is never used; the FSM exits at NIBBLES-1.
- rst_n asserted mid-RUN: the operation is aborted immediately, all outputs return to reset values, and no done is produced.

## Timing
- Accepting edge = edge k (start=1, state IDLE).
- busy=1 for cycles k+1 … k+NIBBLES.
- sum/co are valid and done=1 in cycle k+NIBBLES+1 (latency NIBBLES+1 edges from the start edge to the done pulse). busy=0 in the same cycle.
- Back-to-back throughput: one operation per NIBBLES+1 cycles.
- done pulse width: exactly one cycle.

## Configuration
- ADD_SUB_EN defined:
  - Adds the sub port.
  - With sub=1 on the accepting edge: B is loaded bitwise-inverted, the carry register is forced to 1, and cin is ignored.
  - Result is {co,sum} = A + ~B + 1; co=1 means no borrow (A ≥ B).
  - With sub=0, behaviour is identical to add.
- ADD_SUB_EN undefined: the sub port and the inversion logic are absent; add-only.

## Structure
- Shared package adder_pkg: NIBBLE_W=4 constant; state typedef (IDLE, RUN).
- One sub-module: nibble_adder (combinational 4-bit adder: A, B, cin → Sum[3:0], co), instantiated once.
- Controller holds the FSM, counter, A/B/result shift registers, carry register and output registers.

## Test plan
(NIBBLES=4; checks done timing at k+5 in every case.)
- A=0x1234, B=0x4321, cin=0 → sum=0x5555, co=0, done at k+5, busy high for exactly 4 cycles.
- A=0xFFFF, B=0x0001, cin=0 → sum=0x0000, co=1 (carry ripples through all four nibbles).
- A=0xFFFF, B=0xFFFF, cin=1 → sum=0xFFFF, co=1.
- Second start pulse at k+2 with A=B=0x1111 → ignored; result still 0x5555, no second done. A start coincident with done → accepted; its done arrives 5 cycles later.
- rst_n low at k+2 during 0x1234+0x4321 → busy=0, sum=0, co=0 immediately; no done. A fresh start after release gives a correct result.
- ADD_SUB_EN only: sub=1, A=0x0005, B=0x0007 → sum=0xFFFE, co=0. Then sub=1, A=0x0007, B=0x0005 → sum=0x0002, co=1.
